// File: rtl/one_bit_lca_pkg.sv
// Shared constants and bit-level helpers for the one-bit lookahead cell and
// the wider adders built from it.
package one_bit_lca_pkg;

    localparam int LAT_COMB       = 0;
    localparam int LAT_REGISTERED = 1;

    function automatic int latency_of(input bit registered);
        return registered ? LAT_REGISTERED : LAT_COMB;
    endfunction

    function automatic logic exact_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/lca_cell_comb.sv
// Purely combinational one-bit lookahead cell: generate/propagate, carry-out
// and a sum that is either exact or approximated as the inverted carry.
module lca_cell_comb
    import one_bit_lca_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_c0,
    input  logic i_approx_en,
    output logic o_g,
    output logic o_p,
    output logic o_c1,
    output logic o_sum
);

    logic w_g;
    logic w_p;
    logic w_c1;

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;
    assign w_c1 = w_g | (w_p & i_c0);

    assign o_g   = w_g;
    assign o_p   = w_p;
    assign o_c1  = w_c1;
    // ~C1 is wrong only for the all-zero and all-one operand patterns.
    assign o_sum = i_approx_en ? ~w_c1 : exact_sum(i_a, i_b, i_c0);

endmodule

// File: rtl/one_bit_lca.sv
// One-bit carry-lookahead adder cell with an optional single output register
// stage and valid tracking around the combinational core.
module one_bit_lca
    import one_bit_lca_pkg::*;
#(
    parameter int REGISTERED     = 1,
    parameter bit APPROX_DEFAULT = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic A,
    input  logic B,
    input  logic C0,
    input  logic approx_en,
    output logic out_valid,
    output logic C1,
    output logic SUM,
    output logic G,
    output logic P
);

    localparam int LATENCY = latency_of(REGISTERED != 0);

    logic w_g;
    logic w_p;
    logic w_c1;
    logic w_sum;
    logic w_unused_tieoff;

    // APPROX_DEFAULT only records the integration tie-off value; the port always wins.
    assign w_unused_tieoff = ^{clk, rst_n, APPROX_DEFAULT};

    lca_cell_comb u_cell (
        .i_a         (A),
        .i_b         (B),
        .i_c0        (C0),
        .i_approx_en (approx_en),
        .o_g         (w_g),
        .o_p         (w_p),
        .o_c1        (w_c1),
        .o_sum       (w_sum)
    );

    if (LATENCY == LAT_REGISTERED) begin : g_reg
        logic r_valid;
        logic r_c1;
        logic r_sum;
        logic r_g;
        logic r_p;

        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_c1    <= 1'b0;
                r_sum   <= 1'b0;
                r_g     <= 1'b0;
                r_p     <= 1'b0;
            end else begin
                r_valid <= in_valid;
                if (in_valid) begin
                    r_c1  <= w_c1;
                    r_sum <= w_sum;
                    r_g   <= w_g;
                    r_p   <= w_p;
                end
            end
        end

        assign out_valid = r_valid;
        assign C1        = r_c1;
        assign SUM       = r_sum;
        assign G         = r_g;
        assign P         = r_p;
    end else begin : g_comb
        assign out_valid = in_valid;
        assign C1        = w_c1;
        assign SUM       = w_sum;
        assign G         = w_g;
        assign P         = w_p;
    end

endmodule

// File: tb/tb_one_bit_lca.sv
// Scoreboard bench for one_bit_lca: a registered instance checked one edge
// after each operand, and a combinational instance checked in the same timestep.
module tb_one_bit_lca;

    typedef struct {
        logic c1;
        logic sum;
        logic g;
        logic p;
    } exp_t;

    logic clk;
    logic rst_n;
    logic in_valid;
    logic A;
    logic B;
    logic C0;
    logic approx_en;

    logic r_out_valid, r_c1, r_sum, r_g, r_p;
    logic c_out_valid, c_c1, c_sum, c_g, c_p;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    one_bit_lca #(.REGISTERED(1), .APPROX_DEFAULT(1'b0)) dut_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C0        (C0),
        .approx_en (approx_en),
        .out_valid (r_out_valid),
        .C1        (r_c1),
        .SUM       (r_sum),
        .G         (r_g),
        .P         (r_p)
    );

    one_bit_lca #(.REGISTERED(0), .APPROX_DEFAULT(1'b0)) dut_comb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C0        (C0),
        .approx_en (approx_en),
        .out_valid (c_out_valid),
        .C1        (c_c1),
        .SUM       (c_sum),
        .G         (c_g),
        .P         (c_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic a, input logic b, input logic c, input logic ap);
        exp_t e;
        int   s;
        s     = int'(a) + int'(b) + int'(c);
        e.c1  = (s >= 2);
        e.sum = ap ? !(s >= 2) : s[0];
        e.g   = a & b;
        e.p   = a ^ b;
        return e;
    endfunction

    // Drives one operand at the falling edge, checks the combinational instance
    // before any rising edge, then checks the registered instance after it.
    task automatic drive(input logic a, input logic b, input logic c, input logic ap,
                         input string tag);
        exp_t e;
        @(negedge clk);
        A = a; B = b; C0 = c; approx_en = ap; in_valid = 1'b1;
        sb.push_back(model(a, b, c, ap));
        #1;
        e = model(a, b, c, ap);
        check({tag, "/comb"}, {c_c1, c_sum, c_g, c_p}, {e.c1, e.sum, e.g, e.p});
        check({tag, "/comb_vld"}, {3'b0, c_out_valid}, 4'b0001);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "/sb_empty"}, 4'd0, 4'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "/reg"}, {r_c1, r_sum, r_g, r_p}, {e.c1, e.sum, e.g, e.p});
            check({tag, "/reg_vld"}, {3'b0, r_out_valid}, 4'b0001);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = 1'b0; B = 1'b0; C0 = 1'b0; approx_en = 1'b0;
        #12;
        check("reset_state", {r_c1, r_sum, r_g, r_p}, 4'b0000);
        check("reset_vld", {3'b0, r_out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed exact patterns with hand-derived C1,SUM
        drive(1, 1, 1, 0, "ex111");
        check("ex111_c1sum", {2'b0, r_c1, r_sum}, 4'b0011);
        drive(1, 1, 0, 0, "ex110");
        check("ex110_c1sum", {2'b0, r_c1, r_sum}, 4'b0010);
        drive(1, 0, 0, 0, "ex100");
        check("ex100_c1sum", {2'b0, r_c1, r_sum}, 4'b0001);
        drive(0, 1, 1, 0, "ex011");
        check("ex011_c1sum", {2'b0, r_c1, r_sum}, 4'b0010);

        // Exhaustive exact sweep: 2*C1+SUM must equal the arithmetic sum
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            drive(v[2], v[1], v[0], 0, $sformatf("sweep%0d", i));
            check($sformatf("sweep%0d_arith", i), {2'b0, r_c1, r_sum},
                  4'(int'(v[2]) + int'(v[1]) + int'(v[0])));
        end

        // Approximate mode: wrong SUM only at 000 and 111
        drive(0, 0, 0, 1, "ap000");
        check("ap000_c1sum", {2'b0, r_c1, r_sum}, 4'b0001);
        drive(1, 1, 1, 1, "ap111");
        check("ap111_c1sum", {2'b0, r_c1, r_sum}, 4'b0010);
        drive(1, 0, 1, 1, "ap101");
        check("ap101_c1sum", {2'b0, r_c1, r_sum}, 4'b0010);

        // Hold: in_valid low for 3 cycles after a 110 result, inputs changing
        drive(1, 1, 0, 0, "hold_src");
        @(negedge clk);
        in_valid = 1'b0; A = 1'b0; B = 1'b0; C0 = 1'b1; approx_en = 1'b1;
        #1;
        check("comb_vld_low", {3'b0, c_out_valid}, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", k), {r_c1, r_sum, r_g, r_p}, 4'b1010);
            check($sformatf("hold%0d_vld", k), {3'b0, r_out_valid}, 4'b0000);
        end

        // Asynchronous reset between edges while holding a 111 result
        drive(1, 1, 1, 0, "rst_src");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {r_c1, r_sum, r_g, r_p}, 4'b0000);
        check("async_rst_vld", {3'b0, r_out_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, "post_rst100");
        check("post_rst_c1sum", {2'b0, r_c1, r_sum}, 4'b0001);

        // Combinational instance alone, no clock edge between drive and sample
        @(negedge clk);
        A = 1'b0; B = 1'b1; C0 = 1'b1; approx_en = 1'b0; in_valid = 1'b1;
        #1;
        check("comb011", {2'b0, c_c1, c_sum}, 4'b0010);
        check("comb011_vld", {3'b0, c_out_valid}, 4'b0001);
        in_valid = 1'b0;
        #1;
        check("comb_vld_follow", {3'b0, c_out_valid}, 4'b0000);

        check("sb_drained", 4'(sb.size()), 4'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
